// File: rtl/am2901_seq_pkg.sv
// Shared types and constants for the Am2901 microprogram sequencer.
// Covers opcodes, branch conditions, FSM states, microword field positions and the NOP word.
package am2901_seq_pkg;

  typedef enum logic [2:0] {
    OpCont  = 3'd0,
    OpJmp   = 3'd1,
    OpCjmp  = 3'd2,
    OpJsr   = 3'd3,
    OpRts   = 3'd4,
    OpLdcnt = 3'd5,
    OpLoop  = 3'd6,
    OpHalt  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    CondOne = 2'd0,
    CondZ   = 2'd1,
    CondOvr = 2'd2,
    CondC4  = 2'd3
  } cond_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  localparam int unsigned ALU_LSB  = 0;
  localparam int unsigned ALU_MSB  = 8;
  localparam int unsigned A_LSB    = 9;
  localparam int unsigned A_MSB    = 12;
  localparam int unsigned B_LSB    = 13;
  localparam int unsigned B_MSB    = 16;
  localparam int unsigned CIN_BIT  = 17;
  localparam int unsigned OP_LSB   = 18;
  localparam int unsigned OP_MSB   = 20;
  localparam int unsigned COND_LSB = 21;
  localparam int unsigned COND_MSB = 22;
  localparam int unsigned POL_BIT  = 23;
  localparam int unsigned BR_LSB   = 24;
  localparam int unsigned BR_MSB   = 31;

  // alu_i = 9'b001_000_000, every other field zero (op decodes as CONT)
  localparam logic [31:0] NOP = 32'h0000_0040;

  localparam int unsigned STACK_DEPTH = 4;

endpackage

// File: rtl/seq_stack.sv
// Return-address LIFO for the sequencer; overflow/underflow are reported by the caller.
// Push when full and pop when empty are ignored here.
module seq_stack
  import am2901_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = $clog2(STACK_DEPTH);

  logic [7:0]      r_mem [STACK_DEPTH];
  logic [SpW-1:0]  r_sp;
  logic [IdxW-1:0] w_top;
  logic [SpW-1:0]  w_sp_dec;

  assign w_sp_dec = r_sp - 1'b1;
  assign w_top    = w_sp_dec[IdxW-1:0];
  assign empty    = (r_sp == '0);
  assign full     = (r_sp == SpW'(STACK_DEPTH));
  assign dout     = r_mem[w_top];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp <= '0;
      for (int k = 0; k < STACK_DEPTH; k++) r_mem[k] <= '0;
    end else if (clr) begin
      r_sp <= '0;
    end else if (push && !full) begin
      r_mem[r_sp[IdxW-1:0]] <= din;
      r_sp                  <= r_sp + 1'b1;
    end else if (pop && !empty) begin
      r_sp <= w_sp_dec;
    end
  end

endmodule

// File: rtl/am2901_sequencer.sv
// Microprogram sequencer driving an Am2901 slice from a pipelined control store.
// Next address is combinational from the pipeline register, mpc and the slice flags.
module am2901_sequencer
  import am2901_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [7:0]  uaddr,
  input  logic [31:0] uword,
  output logic [8:0]  i,
  output logic [3:0]  a,
  output logic [3:0]  b,
  output logic        cin,
  input  logic        z,
  input  logic        ovr,
  input  logic        c4,
  output logic        busy,
  output logic        halted,
  output logic        err
);

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pipe;
  logic [7:0]  r_mpc, r_cnt;
  logic        r_err;

  op_e         w_op;
  cond_e       w_cond;
  logic [7:0]  w_br, w_mpc_inc, w_next;
  logic        w_cond_true, w_exec, w_push, w_pop, w_start;
  logic [7:0]  w_stk_dout;
  logic        w_stk_empty, w_stk_full;

  assign w_op      = op_e'(r_pipe[OP_MSB:OP_LSB]);
  assign w_cond    = cond_e'(r_pipe[COND_MSB:COND_LSB]);
  assign w_br      = r_pipe[BR_MSB:BR_LSB];
  assign w_mpc_inc = r_mpc + 8'd1;
  assign w_exec    = (r_state == StRun);
  assign w_start   = (r_state == StIdle) && run;
  assign w_push    = w_exec && (w_op == OpJsr);
  assign w_pop     = w_exec && (w_op == OpRts);

  always_comb begin
    w_cond_true = 1'b0;
    unique case (w_cond)
      CondOne: w_cond_true = 1'b1;
      CondZ:   w_cond_true = z;
      CondOvr: w_cond_true = ovr;
      CondC4:  w_cond_true = c4;
    endcase
    w_cond_true = w_cond_true ^ r_pipe[POL_BIT];
  end

  always_comb begin
    w_next = w_mpc_inc;
    unique case (w_op)
      OpCont:  w_next = w_mpc_inc;
      OpJmp:   w_next = w_br;
      OpCjmp:  w_next = w_cond_true ? w_br : w_mpc_inc;
      OpJsr:   w_next = w_br;
      OpRts:   w_next = w_stk_empty ? w_mpc_inc : w_stk_dout;
      OpLdcnt: w_next = w_mpc_inc;
      OpLoop:  w_next = (r_cnt != 8'd0) ? w_br : w_mpc_inc;
      OpHalt:  w_next = r_mpc;
    endcase
  end

  assign uaddr = (r_state == StIdle) ? 8'd0 : w_next;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (run) w_state_nxt = StRun;
      StRun: begin
        if (!run)                  w_state_nxt = StIdle;
        else if (w_op == OpHalt)   w_state_nxt = StHalt;
      end
      StHalt:  if (!run) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  // Side effects of the executing word apply even when run drops in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe <= NOP;
      r_mpc  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (run) begin
            r_pipe <= uword;
            r_mpc  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
          end
        end
        StRun: begin
          if (w_op == OpLdcnt)                     r_cnt <= w_br;
          else if (w_op == OpLoop && r_cnt != '0)  r_cnt <= r_cnt - 8'd1;
          if ((w_push && w_stk_full) || (w_pop && w_stk_empty)) r_err <= 1'b1;
          if (!run) begin
            r_pipe <= NOP;
            r_mpc  <= '0;
          end else if (w_op != OpHalt) begin
            r_pipe <= uword;
            r_mpc  <= uaddr;
          end
        end
        StHalt: begin
          if (!run) begin
            r_pipe <= NOP;
            r_mpc  <= '0;
          end
        end
        default: begin
          r_pipe <= NOP;
          r_mpc  <= '0;
        end
      endcase
    end
  end

  seq_stack u_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_start),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_mpc_inc),
    .dout  (w_stk_dout),
    .empty (w_stk_empty),
    .full  (w_stk_full)
  );

  assign i      = r_pipe[ALU_MSB:ALU_LSB];
  assign a      = r_pipe[A_MSB:A_LSB];
  assign b      = r_pipe[B_MSB:B_LSB];
  assign cin    = r_pipe[CIN_BIT];
  assign busy   = (r_state == StRun);
  assign halted = (r_state == StHalt);
  assign err    = r_err;

endmodule

// File: tb/tb_am2901_sequencer.sv
// Scoreboard bench for am2901_sequencer: a bench-side control store feeds uword,
// expectations are queued before each step and checked after it.
module tb_am2901_sequencer;

  localparam logic [2:0] CONT = 3'd0, JMP = 3'd1, CJMP = 3'd2, JSR = 3'd3;
  localparam logic [2:0] RTS = 3'd4, LDCNT = 3'd5, LOOP = 3'd6, HALT = 3'd7;
  localparam logic [8:0] NOP_I = 9'b001_000_000;

  localparam int K_UA = 0, K_BUSY = 1, K_HALT = 2, K_ERR = 3, K_I = 4;
  localparam int K_A = 5, K_B = 6, K_CIN = 7, K_CNT = 8;

  logic        clk = 1'b0;
  logic        rst, run, z, ovr, c4;
  logic [7:0]  uaddr;
  logic [31:0] uword;
  logic [8:0]  i;
  logic [3:0]  a, b;
  logic        cin, busy, halted, err;

  logic [31:0] rom [256];
  assign uword = rom[uaddr];

  always #5 clk = ~clk;

  am2901_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .uaddr  (uaddr),
    .uword  (uword),
    .i      (i),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .z      (z),
    .ovr    (ovr),
    .c4     (c4),
    .busy   (busy),
    .halted (halted),
    .err    (err)
  );

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] mk(logic [2:0] op, logic [1:0] cond, logic pol,
                                     logic [7:0] br, logic [8:0] alu = 9'h040,
                                     logic [3:0] fa = 4'h0, logic [3:0] fb = 4'h0,
                                     logic fc = 1'b0);
    return {br, pol, cond, op, fc, fb, fa, alu};
  endfunction

  function automatic logic [31:0] observe(int kind);
    case (kind)
      K_UA:    return 32'(uaddr);
      K_BUSY:  return 32'(busy);
      K_HALT:  return 32'(halted);
      K_ERR:   return 32'(err);
      K_I:     return 32'(i);
      K_A:     return 32'(a);
      K_B:     return 32'(b);
      K_CIN:   return 32'(cin);
      K_CNT:   return 32'(dut.r_cnt);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(string tag, int kind, logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.kind), e.val);
    end
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic clear_rom();
    for (int k = 0; k < 256; k++) rom[k] = mk(CONT, 2'd0, 1'b0, 8'h00);
  endtask

  // Start from IDLE and walk straight-line words up to the one at address 5.
  task automatic run_to5();
    run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      sb_push($sformatf("walk_%0d", k), K_UA, 32'(k));
      tick();
    end
  endtask

  task automatic stop_run();
    run = 1'b0;
    sb_push("stop_busy", K_BUSY, 0);
    sb_push("stop_uaddr", K_UA, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; run = 1'b0; z = 1'b0; ovr = 1'b0; c4 = 1'b0;
    clear_rom();
    #12;
    sb_push("rst_uaddr", K_UA, 0);
    sb_push("rst_i", K_I, 32'(NOP_I));
    sb_push("rst_a", K_A, 0);
    sb_push("rst_b", K_B, 0);
    sb_push("rst_cin", K_CIN, 0);
    sb_push("rst_busy", K_BUSY, 0);
    sb_push("rst_halted", K_HALT, 0);
    sb_push("rst_err", K_ERR, 0);
    settle();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Straight-line program ending in HALT, with field pass-through
    rom[0] = mk(CONT, 2'd0, 1'b0, 8'h00, 9'h1A5, 4'h3, 4'hC, 1'b1);
    rom[1] = mk(CONT, 2'd0, 1'b0, 8'h00, 9'h0F0, 4'h5, 4'hA, 1'b0);
    rom[3] = mk(HALT, 2'd0, 1'b0, 8'h00);
    run = 1'b1;
    sb_push("line_idle_uaddr", K_UA, 0);
    settle();
    sb_push("line_ua1", K_UA, 1);
    sb_push("line_busy", K_BUSY, 1);
    sb_push("line_i0", K_I, 32'h1A5);
    sb_push("line_a0", K_A, 32'h3);
    sb_push("line_b0", K_B, 32'hC);
    sb_push("line_cin0", K_CIN, 1);
    tick();
    sb_push("line_ua2", K_UA, 2);
    sb_push("line_i1", K_I, 32'h0F0);
    sb_push("line_a1", K_A, 32'h5);
    sb_push("line_b1", K_B, 32'hA);
    sb_push("line_cin1", K_CIN, 0);
    tick();
    sb_push("line_ua3", K_UA, 3);
    tick();
    sb_push("line_ua3_halt_word", K_UA, 3);
    sb_push("line_busy_halt_word", K_BUSY, 1);
    tick();
    sb_push("line_ua3_halted", K_UA, 3);
    sb_push("line_halted", K_HALT, 1);
    sb_push("line_busy_off", K_BUSY, 0);
    tick();
    sb_push("line_halt_hold", K_HALT, 1);
    tick();
    run = 1'b0;
    sb_push("line_idle_ua", K_UA, 0);
    sb_push("line_idle_halted", K_HALT, 0);
    sb_push("line_idle_i", K_I, 32'(NOP_I));
    tick();

    // Conditional jump on z, both polarities, then ovr
    clear_rom();
    rom[5] = mk(CJMP, 2'd1, 1'b0, 8'h40);
    z = 1'b1;
    run_to5();
    sb_push("cjmp_z1", K_UA, 32'h40);
    tick();
    z = 1'b0;
    sb_push("cjmp_z0", K_UA, 32'h06);
    settle();
    stop_run();
    rom[5] = mk(CJMP, 2'd1, 1'b1, 8'h40);
    z = 1'b1;
    run_to5();
    sb_push("cjmp_pol_z1", K_UA, 32'h06);
    tick();
    stop_run();
    rom[5] = mk(CJMP, 2'd2, 1'b0, 8'h40);
    z = 1'b0; ovr = 1'b1;
    run_to5();
    sb_push("cjmp_ovr1", K_UA, 32'h40);
    tick();
    stop_run();
    ovr = 1'b0;

    // Nested subroutines, then RTS on an empty stack
    clear_rom();
    rom[8'h00] = mk(JMP, 2'd0, 1'b0, 8'h10);
    rom[8'h10] = mk(JSR, 2'd0, 1'b0, 8'h20);
    rom[8'h20] = mk(JSR, 2'd0, 1'b0, 8'h30);
    rom[8'h30] = mk(RTS, 2'd0, 1'b0, 8'h00);
    rom[8'h21] = mk(RTS, 2'd0, 1'b0, 8'h00);
    rom[8'h11] = mk(RTS, 2'd0, 1'b0, 8'h00);
    rom[8'h12] = mk(HALT, 2'd0, 1'b0, 8'h00);
    run = 1'b1;
    sb_push("jsr_jmp", K_UA, 32'h10);
    tick();
    sb_push("jsr_outer", K_UA, 32'h20);
    tick();
    sb_push("jsr_inner", K_UA, 32'h30);
    tick();
    sb_push("rts_inner", K_UA, 32'h21);
    tick();
    sb_push("rts_outer", K_UA, 32'h11);
    tick();
    sb_push("rts_empty_ua", K_UA, 32'h12);
    sb_push("rts_empty_err_pre", K_ERR, 0);
    tick();
    sb_push("rts_empty_err", K_ERR, 1);
    tick();
    run = 1'b0;
    sb_push("err_sticky_idle", K_ERR, 1);
    sb_push("err_idle_ua", K_UA, 0);
    tick();

    // Five nested pushes: the fifth overflows
    clear_rom();
    rom[8'h00] = mk(JMP, 2'd0, 1'b0, 8'h80);
    for (int k = 0; k < 5; k++) rom[8'h80 + k] = mk(JSR, 2'd0, 1'b0, 8'(8'h81 + k));
    rom[8'h85] = mk(HALT, 2'd0, 1'b0, 8'h00);
    run = 1'b1;
    sb_push("ovf_start_ua", K_UA, 32'h80);
    sb_push("ovf_err_cleared", K_ERR, 0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      sb_push($sformatf("ovf_ua_%0d", k), K_UA, 32'(8'h80 + k));
      sb_push($sformatf("ovf_err_%0d", k), K_ERR, 0);
      tick();
    end
    sb_push("ovf_err_set", K_ERR, 1);
    sb_push("ovf_ua_halt", K_UA, 32'h85);
    tick();
    stop_run();

    // Counted loop: body at 1 runs four times
    clear_rom();
    rom[0] = mk(LDCNT, 2'd0, 1'b0, 8'd3);
    rom[2] = mk(LOOP, 2'd0, 1'b0, 8'd1);
    rom[3] = mk(HALT, 2'd0, 1'b0, 8'd0);
    run = 1'b1;
    begin
      int seq[10] = '{1, 2, 1, 2, 1, 2, 1, 2, 3, 3};
      for (int k = 0; k < 10; k++) begin
        sb_push($sformatf("loop_ua_%0d", k), K_UA, 32'(seq[k]));
        tick();
      end
    end
    sb_push("loop_cnt_end", K_CNT, 0);
    settle();
    stop_run();

    // Address wrap, then reset mid-run
    clear_rom();
    rom[8'h00] = mk(JMP, 2'd0, 1'b0, 8'hFF);
    rom[8'hFF] = mk(CONT, 2'd0, 1'b0, 8'h00, 9'h1FF, 4'hF, 4'hF, 1'b1);
    run = 1'b1;
    sb_push("wrap_jmp", K_UA, 32'hFF);
    tick();
    sb_push("wrap_ff_to_00", K_UA, 32'h00);
    tick();
    sb_push("wrap_again", K_UA, 32'hFF);
    sb_push("wrap_busy", K_BUSY, 1);
    tick();
    #2;
    rst = 1'b1;
    sb_push("midrst_uaddr", K_UA, 0);
    sb_push("midrst_i", K_I, 32'(NOP_I));
    sb_push("midrst_busy", K_BUSY, 0);
    settle();
    #3;
    rst = 1'b0;
    run = 1'b0;
    sb_push("postrst_busy", K_BUSY, 0);
    sb_push("postrst_ua", K_UA, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
